// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port block RAM: lane math,
// byte-lane merge and the clear FSM state encoding.
package ram_pkg;

  // Widest word / lane count the merge helper supports.
  localparam int MAX_DW    = 256;
  localparam int MAX_LANES = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } clr_state_t;

  function automatic int lanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Per-lane mux: lanes with be set take nw, the rest keep old.
  function automatic logic [MAX_DW-1:0] merge(input logic [MAX_DW-1:0]    old_word,
                                               input logic [MAX_DW-1:0]    nw,
                                               input logic [MAX_LANES-1:0] be,
                                               input int                   lane_w);
    logic [4:0] l;
    merge = old_word;
    for (int i = 0; i < MAX_DW; i++) begin
      l = 5'(i / lane_w);
      if (be[l]) merge[i] = nw[i];
    end
  endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One synchronous read port with write-first lane bypass.
// With RAM_OUT_REG_EN defined an extra output register gives 2-cycle latency.
module ram_rd_port
  import ram_pkg::*;
#(
  parameter  int DATAWIDTH = 32,
  parameter  int ADDRWIDTH = 5,
  parameter  int LANEWIDTH = 8,
  localparam int LANES     = lanes(DATAWIDTH, LANEWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 rd_en,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  input  logic [DATAWIDTH-1:0] rd_word,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic [LANES-1:0]     wr_be,
  output logic [DATAWIDTH-1:0] rd_data
);

  logic                 en_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] word_q;
  logic                 we_q;
  logic [ADDRWIDTH-1:0] wa_q;
  logic [DATAWIDTH-1:0] wd_q;
  logic [LANES-1:0]     be_q;
  logic [LANES-1:0]     mask;
  logic [DATAWIDTH-1:0] stage1;

  // word_q is the pre-write array word; the captured write is merged on top.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      word_q <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      be_q   <= '0;
    end else begin
      en_q <= rd_en;
      if (rd_en) begin
        addr_q <= rd_addr;
        word_q <= rd_word;
        we_q   <= we;
        wa_q   <= wr_addr;
        wd_q   <= wr_data;
        be_q   <= wr_be;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no latch can form.
  always_comb begin
    mask   = '0;
    if (we_q && (wa_q == addr_q)) mask = be_q;
    stage1 = DATAWIDTH'(merge(MAX_DW'(word_q), MAX_DW'(wd_q), MAX_LANES'(mask), LANEWIDTH));
  end

`ifdef RAM_OUT_REG_EN
  logic [DATAWIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)  out_q <= '0;
    else if (en_q) out_q <= stage1;
  end

  assign rd_data = out_q;
`else
  assign rd_data = stage1;
`endif

endmodule

// File: rtl/ram_blk_mp_bypassed.sv
// Block RAM: one byte-enabled write port, NRD write-first read ports,
// optional post-reset zero-fill. RAM_OUT_REG_EN adds an output register per port.
module ram_blk_mp_bypassed
  import ram_pkg::*;
#(
  parameter  int DATAWIDTH  = 32,
  parameter  int ADDRWIDTH  = 5,
  parameter  int LANEWIDTH  = 8,
  parameter  int NRD        = 2,
  parameter  int INIT_CLEAR = 1,
  localparam int LANES      = lanes(DATAWIDTH, LANEWIDTH),
  localparam int DEPTH      = 1 << ADDRWIDTH
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     we,
  input  logic [ADDRWIDTH-1:0]     wr_addr,
  input  logic [DATAWIDTH-1:0]     wr_data,
  input  logic [LANES-1:0]         wr_be,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD*ADDRWIDTH-1:0] rd_addr,
  output logic [NRD*DATAWIDTH-1:0] rd_data,
  output logic                     init_busy
);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  clr_state_t           state;
  logic [ADDRWIDTH-1:0] cnt;

  logic                 we_eff;
  logic [ADDRWIDTH-1:0] wa_eff;
  logic [DATAWIDTH-1:0] wd_eff;
  logic [LANES-1:0]     be_eff;

  // Counter wraps only by leaving FILL after the last address.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= (INIT_CLEAR != 0) ? ST_FILL : ST_IDLE;
      cnt       <= '0;
      init_busy <= (INIT_CLEAR != 0);
    end else if (state == ST_FILL) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state     <= ST_IDLE;
        init_busy <= 1'b0;
      end
    end
  end

  // The fill engine owns the write port while active; user writes are dropped.
  always_comb begin
    we_eff = 1'b0;
    wa_eff = wr_addr;
    wd_eff = wr_data;
    be_eff = '0;
    if (state == ST_FILL) begin
      we_eff = 1'b1;
      wa_eff = cnt;
      wd_eff = '0;
      be_eff = '1;
    end else if (we) begin
      we_eff = 1'b1;
      be_eff = wr_be;
    end
  end

  // NOTE: the array is deliberately not reset so it maps onto RAM primitives;
  // zero-fill is done by the FILL state instead.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (be_eff[l]) mem[wa_eff][l*LANEWIDTH +: LANEWIDTH] <= wd_eff[l*LANEWIDTH +: LANEWIDTH];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    ram_rd_port #(
      .DATAWIDTH (DATAWIDTH),
      .ADDRWIDTH (ADDRWIDTH),
      .LANEWIDTH (LANEWIDTH)
    ) u_port (
      .clk     (clk),
      .reset_l (reset_l),
      .rd_en   (rd_en[p]),
      .rd_addr (rd_addr[p*ADDRWIDTH +: ADDRWIDTH]),
      .rd_word (mem[rd_addr[p*ADDRWIDTH +: ADDRWIDTH]]),
      .we      (we_eff),
      .wr_addr (wa_eff),
      .wr_data (wd_eff),
      .wr_be   (be_eff),
      .rd_data (rd_data[p*DATAWIDTH +: DATAWIDTH])
    );
  end

endmodule

// File: tb/tb_ram_blk_mp_bypassed.sv
// Scoreboard bench for ram_blk_mp_bypassed (default parameters, 2 read ports).
// Honours RAM_OUT_REG_EN by switching the expected read latency to 2.
module tb_ram_blk_mp_bypassed;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        init_busy;

  ram_blk_mp_bypassed #(
    .DATAWIDTH (32),
    .ADDRWIDTH (5),
    .LANEWIDTH (8),
    .NRD       (2),
    .INIT_CLEAR(1)
  ) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    int          due;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] model [32];
  logic [31:0] exp_last [2];
  bit          model_busy = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] lane_mix(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = be[l] ? n[l*8 +: 8] : o[l*8 +: 8];
    return r;
  endfunction

  // Advance one edge, then compare every scoreboard entry due now.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check($sformatf("rd%0d@%0d", sb[i].port, cyc),
              (sb[i].due == cyc) ? rd_data[sb[i].port*32 +: 32] : 32'hxxxx_xxxx, sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  // Drive one cycle of stimulus and push what each port must show LAT edges later.
  task automatic cycle(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [1:0] en,
                       input logic [4:0] a0, input logic [4:0] a1);
    logic [4:0] a;
    we = w; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = en; rd_addr = {a1, a0};
    if (w && !model_busy) model[wa] = lane_mix(model[wa], wd, be);
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? a0 : a1;
      if (en[p]) exp_last[p] = model[a];
      sb.push_back(sb_t'{port: p, due: cyc + LAT, exp: exp_last[p]});
    end
    step();
  endtask

  task automatic idle_inputs();
    we = 1'b0; wr_be = '0; rd_en = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    repeat (LAT + 1) step();
    reset_l = 1'b0;
    #3;
    check("rst_rd0", rd_data[31:0], 32'h0);
    check("rst_rd1", rd_data[63:32], 32'h0);
    check("rst_busy", {31'b0, init_busy}, 32'h1);
    repeat (2) step();
    exp_last[0] = '0;
    exp_last[1] = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_busy = 1'b1;
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  // Count busy samples from release; optionally try a write to addr 2 in fill cycle 5.
  task automatic fill_run(input bit poke);
    int high;
    high = init_busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      if (poke && k == 5) cycle(1'b1, 5'd2, 32'hBAD0_BAD0, 4'hF, 2'b00, 5'd0, 5'd0);
      else                cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b00, 5'd0, 5'd0);
      if (!init_busy) break;
      high++;
    end
    model_busy = 1'b0;
    check("busy_cycles", 32'(high), 32'd32);
  endtask

  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_last[0] = '0;
    exp_last[1] = '0;

    // Reset and zero-fill, then every address reads zero on both ports.
    do_reset();
    fill_run(1'b0);
    for (int i = 0; i < 32; i++) cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'(i), 5'(31 - i));

    // Full-word write then read.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 2'b00, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b01, 5'd5, 5'd0);

    // Same-edge partial write and read on both ports: lane merge.
    cycle(1'b1, 5'd7, 32'h1122_3344, 4'hF, 2'b00, 5'd0, 5'd0);
    cycle(1'b1, 5'd7, 32'hAABB_CCDD, 4'h5, 2'b11, 5'd7, 5'd7);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd7, 5'd7);

    // Port 1 holds while disabled and addr 3 is rewritten.
    cycle(1'b1, 5'd3, 32'hCAFE_F00D, 4'hF, 2'b00, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b10, 5'd0, 5'd3);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd3, 32'h0101_0101 * (i + 2), 4'hF, 2'b00, 5'd0, 5'd3);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b01, 5'd3, 5'd0);

    // we with no lanes enabled is a no-op, including on a same-edge read.
    cycle(1'b1, 5'd2, 32'h1234_5678, 4'hF, 2'b00, 5'd0, 5'd0);
    cycle(1'b1, 5'd2, 32'hFFFF_FFFF, 4'h0, 2'b11, 5'd2, 5'd2);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd2, 5'd2);

    // Random traffic over a few addresses to provoke collisions.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
    end

    // Abort a fill around address 10; the restarted fill clears everything
    // and a write in fill cycle 5 is dropped.
    cycle(1'b1, 5'd20, 32'h55AA_55AA, 4'hF, 2'b00, 5'd0, 5'd0);
    do_reset();
    repeat (8) cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b00, 5'd0, 5'd0);
    do_reset();
    fill_run(1'b1);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd2, 5'd20);
    cycle(1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd31, 5'd5);

    idle_inputs();
    repeat (LAT + 1) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_blk_mp_bypassed.md
Name: ram_blk_mp_bypassed

Overview:
- Parametrised block RAM with one write port and NRD independent synchronous read ports.
- Write has per-lane byte enables; each read port has write-first bypass with per-lane merge.
- Optional post-reset hardware zero-fill of the whole array.
- Successor to the single-read, full-word, write-first dual-port RAM. Used for the register file, multi-issue operand fetch and small caches in the nanorv32 core.

Parameters:
- DATAWIDTH, 32, bits per word; must be a multiple of LANEWIDTH.
- ADDRWIDTH, 5, address bits; DEPTH = 1 << ADDRWIDTH words.
- LANEWIDTH, 8, bits per write-enable lane; LANES = DATAWIDTH/LANEWIDTH.
- NRD, 2, number of read ports (1..4).
- INIT_CLEAR, 1, 1 = zero-fill the array after reset; 0 = no fill, contents undefined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- wr_addr  in  ADDRWIDTH  write address.
- wr_data  in  DATAWIDTH  write data.
- wr_be  in  LANES  lane enables; lane i covers wr_data[i*LANEWIDTH +: LANEWIDTH].
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*ADDRWIDTH  port p address at [p*ADDRWIDTH +: ADDRWIDTH].
- rd_data  out  NRD*DATAWIDTH  port p data at [p*DATAWIDTH +: DATAWIDTH].
- init_busy  out  1  high while zero-fill runs; writes are ignored while high.

Behaviour:
- Reset (reset_l low, asynchronous):
  - all rd_data = 0.
  - init_busy = 1 if INIT_CLEAR, else 0.
  - clear counter = 0.
  - array contents are not reset.
- Clear FSM states:
  - IDLE: entered from reset when INIT_CLEAR=0, or after the fill completes.
  - FILL: entered from reset when INIT_CLEAR=1.
- FILL operation:
  - First edge after reset_l rises writes 0 to address 0; counter increments each cycle.
  - After the write to DEPTH-1, moves to IDLE and drops init_busy on the same edge. init_busy is high for exactly DEPTH cycles after reset release.
  - Counter wraps by state exit, never by overflow.
  - Reset mid-FILL restarts at address 0.
- Write:
  - In IDLE with we=1, each lane with wr_be[i]=1 is written at the clock edge; lanes with wr_be[i]=0 are unchanged.
  - we=1 with wr_be=0 is a no-op.
  - Writes while init_busy=1 are dropped.
- Read (per port p, independent):
  - rd_en[p]=1 at edge N: rd_data[p] after edge N = contents of rd_addr[p] including the edge-N write (write-first).
  - Same-cycle collision: if we and wr_addr == rd_addr[p], enabled lanes return wr_data and the other lanes return old contents.
  - rd_en[p]=0: rd_data[p] holds its previous value.
  - Latency is 1 cycle.
- During FILL:
  - Reads return 0 for addresses already cleared or being cleared this edge.
  - Other addresses return undefined data.
  - Bench reads only after init_busy falls.
- Concurrency:
  - All NRD ports may read the same address simultaneously; all receive identical data.
  - No read-port conflicts or stalls.

Optional Feature:
- Macro: RAM_OUT_REG_EN.
- Defined:
  - Extra output register per port; read latency 2 cycles.
  - The stage-1 value (bypass-merged, as above) advances when the port's rd_en from the previous cycle was 1; otherwise the output holds.
  - The output register resets to 0.
  - A write at edge N+1 does NOT alter data of a read issued at edge N.
- Undefined: latency 1 as specified above.

Decomposition:
- Package ram_pkg:
  - function lanes(DATAWIDTH, LANEWIDTH).
  - lane-merge function merge(old, new, be) returning per-lane mux.
  - localparam clear-FSM state encodings ST_IDLE, ST_FILL.
- Sub-module ram_rd_port, instantiated NRD times. Contains:
  - registered address, rd_en, write address, we, wr_be and wr_data for collision compare.
  - merge mux.
  - optional output register.
- Array, write logic and clear FSM live in the top.

Test Plan:
- Reset then idle, INIT_CLEAR=1, DEPTH=32 -> init_busy high exactly 32 cycles. Then every address reads 0x00000000 on both ports.
- Write 0xDEADBEEF, be=0xF to addr 5; next cycle read addr 5 on port 0 -> rd_data[0]=0xDEADBEEF after 1 edge (2 with RAM_OUT_REG_EN).
- addr 7 holds 0x11223344. Same edge: we, be=0x5, wr_data=0xAABBCCDD to addr 7, plus read addr 7 on ports 0 and 1 -> both return 0x11BB33DD.
- Read addr 3 with rd_en[1]=1, then rd_en[1]=0 for 4 cycles while writing addr 3 -> rd_data[1] holds the old value throughout.
- Assert reset_l low at fill address 10, release -> fill restarts at 0; init_busy is high 32 cycles after release. A write issued at cycle 5 of fill is dropped (address reads 0).
- we=1, be=0 to addr 2 holding 0x12345678 -> reads still return 0x12345678.
